fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Owns the program counter and issues instruction fetches to instruction memory over a valid/ready request channel plus a valid-only response channel.
- Presents fetched instructions to decode with a valid/ready handshake.
- Accepts redirects from execute (taken branch or jump) and flushes wrong-path fetches.
- Sits between the PC register/address logic and the decode stage, and allows at most one outstanding memory request.

Parameters:
ADDR_SIZE, 32, PC and memory address width
RESET_PC, 32'h80000000, first fetch address after reset
INSTR_W, 32, instruction word width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_SIZE  fetch address
imem_rsp_valid  in  1  response valid; exactly one per accepted request, earliest one cycle after acceptance
imem_rsp_data  in  INSTR_W  instruction word
id_valid  out  1  instruction valid to decode
id_ready  in  1  decode accepts
id_pc  out  ADDR_SIZE  PC of presented instruction
id_instr  out  INSTR_W  presented instruction
redirect_valid  in  1  single-cycle redirect pulse from execute
redirect_target  in  ADDR_SIZE  redirect address
busy  out  1  request outstanding (WAIT or DRAIN)

Behaviour:
- Reset (reset=0, async):
  - state=REQ, pc=RESET_PC.
  - imem_req_valid=0, id_valid=0, busy=0.
  - id_pc=0, id_instr=0.
  - Requests start on the first clk edge after release. imem_req_valid is gated by a registered "out of reset" flag, so it stays 0 in the release cycle.
- States:
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready, go to WAIT and capture req_pc=pc.
  - WAIT: on imem_rsp_valid, load id_pc=req_pc and id_instr=imem_rsp_data, set id_valid=1, set pc=req_pc+4, and go to HOLD.
  - HOLD: id_valid=1. On id_ready, clear id_valid and go to REQ.
  - DRAIN: waiting for a flushed response. On imem_rsp_valid, discard the data, keep id_valid=0, and go to REQ.
- Redirect (redirect_valid=1), evaluated in every state:
  - Takes priority over all other events in the same cycle.
  - pc <= {redirect_target[ADDR_SIZE-1:1], 1'b0}. Bit 0 is always cleared.
  - id_valid cleared the next cycle, including in HOLD even if id_ready=1 in that cycle; that instruction counts as consumed.
  - In REQ with imem_req_ready=1 in the same cycle, the request is accepted on the wire: go to DRAIN.
  - In REQ without ready: stay in REQ. The next request uses the new pc.
  - In WAIT, response not arriving: go to DRAIN.
  - In WAIT with imem_rsp_valid in the same cycle: discard the response and go to REQ.
  - In DRAIN: stay in DRAIN; the new target overwrites pc.
  - In HOLD: go to REQ.
- Request stability: once imem_req_valid is asserted, imem_req_addr stays stable until accepted, unless a redirect occurs. In that case the address changes in the following cycle, so the request is not held stable through the redirect.
- PC increment: pc+4 wraps modulo 2^ADDR_SIZE, so 32'hFFFFFFFC+4 = 0.
- Throughput:
  - Minimum of 3 cycles per instruction with zero-latency ready and one-cycle response: REQ, WAIT, HOLD.
  - No prefetch.
- Outputs id_pc and id_instr are registered and held stable while id_valid=1.
- busy = (state==WAIT) or (state==DRAIN).
- A response arriving in REQ or HOLD is a protocol violation: ignore it; checked by assertion.

Test Plan:
- Reset release, imem_req_ready=1, response 1 cycle later with data 32'h00000013 -> req addr 32'h80000000; id_valid=1 with id_pc=32'h80000000 and id_instr=32'h00000013. Next request is at 32'h80000004.
- Decode backpressure: id_ready=0 for 5 cycles in HOLD -> id_valid/id_pc/id_instr stable; no new request issued. id_ready=1 -> request for pc+4 the next cycle.
- Redirect in WAIT to 32'h80000101, response 3 cycles later -> response discarded, id_valid stays 0. Next request addr is 32'h80000100.
- Redirect in the same cycle as imem_rsp_valid in WAIT -> no id_valid. Next request is at the target.
- Redirect during HOLD with id_ready=1 -> id_valid drops. Next fetch is the target, not pc+4.
- Wrap-around: redirect to 32'hFFFFFFFC, complete the fetch -> next request addr 32'h00000000.
- Reset asserted mid-WAIT -> all outputs return to reset values immediately. After release, fetch restarts at RESET_PC; a stale response arriving in REQ is ignored.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one fetch at a time to
// instruction memory, presents the result to decode and handles redirects.
//
// state | meaning
// REQ   | request for pc is on the wire (after the first post-reset edge)
// WAIT  | request accepted, waiting for its response
// HOLD  | fetched instruction presented to decode, waiting for id_ready
// DRAIN | flushed request outstanding, its response will be discarded
module fetch_sequencer #(
  parameter int                   ADDR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC  = 32'h8000_0000,
  parameter int                   INSTR_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ADDR_SIZE-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INSTR_W-1:0]   imem_rsp_data,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [ADDR_SIZE-1:0] id_pc,
  output logic [INSTR_W-1:0]   id_instr,
  input  logic                 redirect_valid,
  input  logic [ADDR_SIZE-1:0] redirect_target,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e               state_q;
  logic [ADDR_SIZE-1:0] pc_q;
  logic [ADDR_SIZE-1:0] req_pc_q;
  logic                 id_valid_q;
  logic [ADDR_SIZE-1:0] id_pc_q;
  logic [INSTR_W-1:0]   id_instr_q;
  logic                 run_q;
  logic                 req_fire;
  logic [ADDR_SIZE-1:0] redirect_pc;
  logic                 unused_target_lsb;

  // Targets are halfword aligned at most; bit 0 is never fetched.
  assign redirect_pc       = {redirect_target[ADDR_SIZE-1:1], 1'b0};
  assign unused_target_lsb = redirect_target[0];

  assign imem_req_valid = run_q && (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign id_valid       = id_valid_q;
  assign id_pc          = id_pc_q;
  assign id_instr       = id_instr_q;
  assign busy           = (state_q == S_WAIT) || (state_q == S_DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      run_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) begin
        pc_q       <= redirect_pc;
        id_valid_q <= 1'b0;
        // A response landing with the redirect still retires the outstanding request.
        case (state_q)
          S_REQ:   if (req_fire) state_q <= S_DRAIN;
          S_WAIT:  state_q <= imem_rsp_valid ? S_REQ : S_DRAIN;
          S_DRAIN: if (imem_rsp_valid) state_q <= S_REQ;
          S_HOLD:  state_q <= S_REQ;
          default: state_q <= S_REQ;
        endcase
      end else begin
        case (state_q)
          S_REQ: begin
            if (req_fire) begin
              req_pc_q <= pc_q;
              state_q  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              id_valid_q <= 1'b1;
              id_pc_q    <= req_pc_q;
              id_instr_q <= imem_rsp_data;
              pc_q       <= req_pc_q + ADDR_SIZE'(4);
              state_q    <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (id_ready) begin
              id_valid_q <= 1'b0;
              state_q    <= S_REQ;
            end
          end
          S_DRAIN: begin
            if (imem_rsp_valid) state_q <= S_REQ;
          end
          default: state_q <= S_REQ;
        endcase
      end
    end
  end

  // Responses only belong to an outstanding request; one straddling reset release is tolerated.
  a_rsp_only_when_outstanding : assert property (
    @(posedge clk) disable iff (!reset || !run_q)
    !(imem_rsp_valid && ((state_q == S_REQ) || (state_q == S_HOLD)))
  );

endmodule
